// File: rtl/bcd_seg_scanner.sv
// Multiplexed 7-segment driver: snapshots a BCD word on load and scans it digit by
// digit with a one-cycle blank gap per slot and optional leading-zero blanking.
module bcd_seg_scanner #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        unique case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h40;
        endcase
    endfunction

    logic [4*DIGITS-1:0] snapshot;
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;

    logic [DIGITS-1:0]   blank_mask;
    logic [3:0]          cur_digit;
    logic                cur_blank;
    logic [6:0]          seg_d;
    logic [DIGITS-1:0]   an_d;

    // Walk from the most significant digit down; a digit is blanked while every
    // digit at or above it is zero. An invalid code is non-zero, so it stops blanking.
    always_comb begin : lz_scan
        logic upper_zero;
        upper_zero = 1'b1;
        blank_mask = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            upper_zero    = upper_zero & (snapshot[4*k +: 4] == 4'd0);
            blank_mask[k] = blank_lz & upper_zero;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        cur_digit = '0;
        cur_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_digit = snapshot[4*k +: 4];
                cur_blank = blank_mask[k];
            end
        end
        an_d  = '0;
        seg_d = '0;
        if (cnt != '0) begin
            an_d  = DIGITS'(1) << idx;
            seg_d = cur_blank ? 7'h00 : seg_decode(cur_digit);
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values;
    // the outputs decode the (cnt, idx) being left, not the one being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snapshot <= '0;
            cnt      <= '0;
            idx      <= '0;
            seg      <= '0;
            an       <= '0;
            frame    <= 1'b0;
        end else begin
            if (load) begin
                snapshot <= bcd_in;
            end
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            seg   <= seg_d;
            an    <= an_d;
            frame <= (cnt == '0) && (idx == '0);
        end
    end

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Scoreboard bench for bcd_seg_scanner (DIGITS=4, SCAN_DIV=4): expected outputs are
// queued as each cycle's stimulus is driven and popped once the edge has happened.
module tb_bcd_seg_scanner;

    localparam int ND = 4;
    localparam int SD = 4;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       frame;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [15:0]   bcd_in = '0;
    logic          load = 1'b0;
    logic          blank_lz = 1'b0;
    logic [6:0]    seg;
    logic [3:0]    an;
    logic          frame;

    int            vectors = 0;
    int            miscompares = 0;
    exp_t          sb_q[$];
    exp_t          last_exp;
    exp_t          pop;
    int            m_pos = 0;
    logic [15:0]   m_snap = '0;
    logic [6:0]    seg_table [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    bcd_seg_scanner #(.DIGITS(ND), .SCAN_DIV(SD)) dut (
        .clk      (clk),
        .rst      (rst),
        .bcd_in   (bcd_in),
        .load     (load),
        .blank_lz (blank_lz),
        .seg      (seg),
        .an       (an),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, queue what the pins must show after the edge,
    // then step past the edge. Position m_pos counts edges since reset release.
    task automatic drive_cycle(input logic ld, input logic [15:0] bcd, input logic blz);
        exp_t e;
        int   slot_cnt;
        int   slot_idx;
        int   dig;
        load     = ld;
        bcd_in   = bcd;
        blank_lz = blz;
        slot_cnt = m_pos % SD;
        slot_idx = (m_pos / SD) % ND;
        e.frame  = (slot_cnt == 0) && (slot_idx == 0);
        if (slot_cnt == 0) begin
            e.an  = '0;
            e.seg = '0;
        end else begin
            e.an = 4'(1 << slot_idx);
            dig  = int'((m_snap >> (4 * slot_idx)) & 16'hF);
            if (blz && slot_idx > 0 && (m_snap >> (4 * slot_idx)) == 16'h0)
                e.seg = '0;
            else
                e.seg = seg_table[dig];
        end
        sb_q.push_back(e);
        last_exp = e;
        if (ld) m_snap = bcd;
        m_pos++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vectors++;
        if ({an, seg, frame} !== 12'h0) begin
            miscompares++;
            $display("FAIL reset_hold: an=%b seg=%h frame=%b, want all 0", an, seg, frame);
        end
        @(negedge clk);
        rst   = 1'b1;
        m_pos = 0;
        m_snap = '0;
        for (int i = 0; i < 40; i++) begin
            drive_cycle(1'b0, 16'h0, 1'b0);
            pop = sb_q.pop_front();
            vectors++;
            if ({an, seg, frame} !== pop) begin
                miscompares++;
                $display("FAIL startup[%0d]: an=%b seg=%h frame=%b, want an=%b seg=%h frame=%b",
                         i, an, seg, frame, pop.an, pop.seg, pop.frame);
            end
            if (i == 0 || i == 1 || i == 16) begin
                vectors++;
                if ((i == 1 && an !== 4'b0001) || (i != 1 && (frame !== 1'b1 || an !== 4'b0000))) begin
                    miscompares++;
                    $display("FAIL startup_edge%0d: an=%b frame=%b", i + 1, an, frame);
                end
            end
        end
    endtask

    task automatic test_decode();
        logic [15:0] words [3] = '{16'h1234, 16'h5678, 16'h9090};
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 2 * ND * SD; i++) begin
                drive_cycle(i == 0, words[w], 1'b0);
                pop = sb_q.pop_front();
                vectors++;
                if ({an, seg, frame} !== pop) begin
                    miscompares++;
                    $display("FAIL decode_%h[%0d]: an=%b seg=%h, want an=%b seg=%h",
                             words[w], i, an, seg, pop.an, pop.seg);
                end
                if (w == 0 && an == 4'b0100) begin
                    vectors++;
                    if (seg !== 7'h5B) begin
                        miscompares++;
                        $display("FAIL decode_1234_digit2: seg=%h want 5b", seg);
                    end
                end
            end
        end
    endtask

    task automatic test_blanking();
        logic [15:0] words [3] = '{16'h0070, 16'h0000, 16'h0000};
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 2 * ND * SD; i++) begin
                drive_cycle(i == 0, words[w], w != 2);
                pop = sb_q.pop_front();
                vectors++;
                if ({an, seg, frame} !== pop) begin
                    miscompares++;
                    $display("FAIL blank_%0d[%0d]: an=%b seg=%h, want an=%b seg=%h",
                             w, i, an, seg, pop.an, pop.seg);
                end
            end
        end
    endtask

    task automatic test_invalid();
        for (int i = 0; i < 2 * ND * SD; i++) begin
            drive_cycle(i == 0, 16'h0A0F, 1'b1);
            pop = sb_q.pop_front();
            vectors++;
            if ({an, seg, frame} !== pop) begin
                miscompares++;
                $display("FAIL invalid[%0d]: an=%b seg=%h, want an=%b seg=%h",
                         i, an, seg, pop.an, pop.seg);
            end
        end
    endtask

    task automatic test_load_mid_slot();
        int budget;
        // Preload 0x0090 and run to the first SHOW cycle of digit 1.
        budget = 0;
        drive_cycle(1'b1, 16'h0090, 1'b0);
        void'(sb_q.pop_front());
        while (last_exp.an !== 4'b0010 && budget < 40) begin
            drive_cycle(1'b0, 16'h0090, 1'b0);
            pop = sb_q.pop_front();
            vectors++;
            if ({an, seg, frame} !== pop) begin
                miscompares++;
                $display("FAIL load_pre: an=%b seg=%h, want an=%b seg=%h", an, seg, pop.an, pop.seg);
            end
            budget++;
        end
        vectors++;
        if (budget >= 40 || seg !== 7'h6F) begin
            miscompares++;
            $display("FAIL load_reach_digit1: budget=%0d seg=%h want 6f", budget, seg);
        end
        for (int i = 0; i < 8; i++) begin
            drive_cycle(i == 0, (i == 0) ? 16'h0050 : 16'h0000, 1'b0);
            pop = sb_q.pop_front();
            vectors++;
            if ({an, seg, frame} !== pop) begin
                miscompares++;
                $display("FAIL load_mid[%0d]: an=%b seg=%h, want an=%b seg=%h",
                         i, an, seg, pop.an, pop.seg);
            end
            if (i < 2) begin
                vectors++;
                if (an !== 4'b0010 || seg !== ((i == 0) ? 7'h6F : 7'h6D)) begin
                    miscompares++;
                    $display("FAIL load_latency[%0d]: an=%b seg=%h", i, an, seg);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int budget;
        budget = 0;
        while (last_exp.an !== 4'b0100 && budget < 40) begin
            drive_cycle(budget == 0, 16'h4321, 1'b0);
            pop = sb_q.pop_front();
            budget++;
        end
        vectors++;
        if (budget >= 40 || an !== 4'b0100) begin
            miscompares++;
            $display("FAIL areset_reach: budget=%0d an=%b want 0100", budget, an);
        end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if ({an, seg, frame} !== 12'h0) begin
            miscompares++;
            $display("FAIL areset_immediate: an=%b seg=%h frame=%b, want all 0", an, seg, frame);
        end
        load   = 1'b1;
        bcd_in = 16'h1234;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({an, seg, frame} !== 12'h0) begin
            miscompares++;
            $display("FAIL areset_held: an=%b seg=%h frame=%b, want all 0", an, seg, frame);
        end
        load = 1'b0;
        @(negedge clk);
        rst    = 1'b1;
        m_pos  = 0;
        m_snap = '0;
        for (int i = 0; i < 2 * ND * SD; i++) begin
            drive_cycle(1'b0, 16'h0, 1'b0);
            pop = sb_q.pop_front();
            vectors++;
            if ({an, seg, frame} !== pop) begin
                miscompares++;
                $display("FAIL restart[%0d]: an=%b seg=%h frame=%b, want an=%b seg=%h frame=%b",
                         i, an, seg, frame, pop.an, pop.seg, pop.frame);
            end
        end
    endtask

    initial begin
        #12;
        test_reset();
        test_decode();
        test_blanking();
        test_invalid();
        test_load_mid_slot();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
